// File: rtl/sp_burst_drain.sv
// sp_burst_drain: captures one contiguous burst of SP results into a small
// buffer, then replays the words in arrival order over a valid/ready port,
// flagging the final word with out_last.
//
// Optional feature (macro SP_BURST_SUM_EN): when defined, one extra summary
// word (saturated signed sum of the stored words) is appended after the last
// data word, and out_last marks that summary word instead.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for the first in_valid of a burst
// FILL  | storing burst words until in_valid drops
// DRAIN | replaying stored words; new input words are dropped (ovf=1)

module sp_burst_drain #(
    parameter int DEPTH = 8,
    parameter int DW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          ovf
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [1:0]    state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_cnt;
    logic [AW-1:0] rd_ptr;
    logic          ovf_r;

    logic          last_data;
    logic          store_en;
    logic [AW-1:0] wr_idx;
    logic [DW-1:0] word_sel;
    logic          last_sel;

    // rd_ptr points at the last stored word when it equals wr_cnt-1
    assign last_data = ({1'b0, rd_ptr} == (wr_cnt - CNT_ONE));
    assign store_en  = in_valid &&
                       ((state == S_IDLE) || ((state == S_FILL) && (wr_cnt < CNT_FULL)));
    assign wr_idx    = (state == S_IDLE) ? '0 : wr_cnt[AW-1:0];

`ifdef SP_BURST_SUM_EN
    localparam int SW = DW + AW;
    localparam logic signed [SW-1:0] SUM_MAX = {{(AW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SUM_MIN = {{(AW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [SW-1:0] acc;
    logic signed [SW-1:0] in_ext;
    logic [DW-1:0]        sum_sat;
    logic                 sum_phase;

    assign in_ext = {{AW{in_data[DW-1]}}, in_data};

    // Clamp the wide accumulator into the DW-bit two's complement range
    always_comb begin
        sum_sat = acc[DW-1:0];
        if (acc > SUM_MAX) begin
            sum_sat = {1'b0, {(DW-1){1'b1}}};
        end else if (acc < SUM_MIN) begin
            sum_sat = {1'b1, {(DW-1){1'b0}}};
        end
    end

    // Accumulate exactly the words that get stored; restart on a new burst
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (store_en) begin
            acc <= (state == S_IDLE) ? in_ext : (acc + in_ext);
        end
    end

    assign word_sel = sum_phase ? sum_sat : mem[rd_ptr];
    assign last_sel = sum_phase;
`else
    assign word_sel = mem[rd_ptr];
    assign last_sel = last_data;
`endif

    // Burst buffer write port; contents need no reset since wr_cnt gates reads
    always_ff @(posedge clk) begin
        if (rst_n && store_en) begin
            mem[wr_idx] <= in_data;
        end
    end

    // Control FSM: fill, then drain with handshake, sticky overflow tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            wr_cnt <= '0;
            rd_ptr <= '0;
            ovf_r  <= 1'b0;
`ifdef SP_BURST_SUM_EN
            sum_phase <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        wr_cnt <= CNT_ONE;
                        ovf_r  <= 1'b0;
                        state  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (in_valid) begin
                        if (wr_cnt < CNT_FULL) begin
                            wr_cnt <= wr_cnt + CNT_ONE;
                        end else begin
                            ovf_r <= 1'b1;
                        end
                    end else begin
                        rd_ptr <= '0;
                        state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (in_valid) begin
                        ovf_r <= 1'b1;
                    end
                    if (out_ready) begin
`ifdef SP_BURST_SUM_EN
                        if (sum_phase) begin
                            sum_phase <= 1'b0;
                            state     <= S_IDLE;
                        end else if (last_data) begin
                            sum_phase <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
`else
                        if (last_data) begin
                            state <= S_IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on registered state, never on out_ready
    assign out_valid = (state == S_DRAIN);
    assign busy      = (state != S_IDLE);
    assign out_data  = out_valid ? word_sel : '0;
    assign out_last  = out_valid && last_sel;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_sp_burst_drain.sv
// Bench for sp_burst_drain: randomized bursts and back-pressure compared
// against a queue-based reference of what the replay should contain.
module tb_sp_burst_drain;

    localparam int DEPTH = 8;
    localparam int DW    = 9;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] bq[$];
    logic [DW-1:0] exp_q[$];
    logic          ovf_exp;

    sp_burst_drain #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .busy(busy), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: first DEPTH words survive; optional saturated sum appended
    task automatic build_model();
        int s;
        s = 0;
        exp_q.delete();
        for (int i = 0; i < bq.size(); i++) begin
            if (i < DEPTH) begin
                exp_q.push_back(bq[i]);
                s += int'($signed(bq[i]));
            end
        end
        ovf_exp = (bq.size() > DEPTH);
`ifdef SP_BURST_SUM_EN
        if (s > 255) s = 255;
        if (s < -256) s = -256;
        exp_q.push_back(s[DW-1:0]);
`endif
    endtask

    // Drive bq as one contiguous burst; leaves in_valid low at a negedge in FILL
    task automatic send_burst();
        build_model();
        for (int i = 0; i < bq.size(); i++) begin
            in_valid = 1'b1;
            in_data  = bq[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL fill_state got valid=%b busy=%b exp valid=0 busy=1", out_valid, busy);
        end
    endtask

    // Collect the replay with random back-pressure, optional in_valid noise
    task automatic drain(input int ready_pct, input bit inject);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (exp_q.size() != 0) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0] ||
                out_last !== (exp_q.size() == 1) || busy !== 1'b1) begin
                bad++;
                $display("FAIL drain_word got v=%b d=%h l=%b b=%b exp v=1 d=%h l=%b b=1",
                         out_valid, out_data, out_last, busy, exp_q[0], exp_q.size() == 1);
            end
            out_ready = ($urandom_range(99) < ready_pct);
            if (inject && $urandom_range(2) == 0) begin
                in_valid = 1'b1;
                in_data  = DW'($urandom);
                ovf_exp  = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (out_ready) void'(exp_q.pop_front());
            @(negedge clk);
            cyc++;
            if (cyc > 500) begin
                total++;
                bad++;
                $display("FAIL drain_timeout got cycles=%0d exp <=500", cyc);
                break;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
            busy !== 1'b0 || ovf !== ovf_exp) begin
            bad++;
            $display("FAIL drain_end got v=%b d=%h l=%b b=%b ovf=%b exp v=0 d=0 l=0 b=0 ovf=%b",
                     out_valid, out_data, out_last, busy, ovf, ovf_exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
            busy !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset got v=%b d=%h l=%b b=%b ovf=%b exp all 0",
                     out_valid, out_data, out_last, busy, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bq = '{9'h003, 9'h1FF, 9'h007};
        send_burst();
        drain(100, 1'b0);
    endtask

    task automatic test_overflow();
        bq.delete();
        for (int i = 1; i <= 10; i++) bq.push_back(DW'(i));
        send_burst();
        drain(100, 1'b0);
        bq.delete();
        for (int i = 0; i < DEPTH; i++) bq.push_back(DW'(i + 32));
        send_burst();
        drain(60, 1'b0);
    endtask

    task automatic test_stall();
        bq = '{9'h005, 9'h006};
        send_burst();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== 9'h005) begin
                bad++;
                $display("FAIL stall_hold got v=%b d=%h exp v=1 d=005", out_valid, out_data);
            end
        end
        // drain() re-enters one negedge later; keep ready low so nothing is lost
        drain(100, 1'b0);
    endtask

    task automatic test_drain_inject();
        bq = '{9'h011, 9'h022, 9'h033};
        send_burst();
        drain(70, 1'b1);
        ovf_exp = 1'b1;
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL inject_ovf got ovf=%b exp 1", ovf);
        end
        bq = '{9'h0AA};
        send_burst();
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got ovf=%b exp 0", ovf);
        end
        drain(100, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        bq = '{9'h011, 9'h022, 9'h033, 9'h044};
        send_burst();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 9'h1AB;
        @(negedge clk);
        total++;
        if (ovf !== 1'b1 || out_data !== 9'h022) begin
            bad++;
            $display("FAIL pre_reset got ovf=%b d=%h exp ovf=1 d=022", ovf, out_data);
        end
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0 || out_data !== '0) begin
            bad++;
            $display("FAIL mid_reset got v=%b b=%b ovf=%b d=%h exp 0 0 0 0",
                     out_valid, busy, ovf, out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bq = '{9'h055};
        send_burst();
        drain(100, 1'b0);
    endtask

    task automatic test_sum();
        bq = '{9'h0C8, 9'h064};
        send_burst();
        drain(100, 1'b0);
        bq = '{9'h138, 9'h19C};
        send_burst();
        drain(50, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int len;
            len = $urandom_range(DEPTH + 4, 1);
            bq.delete();
            for (int i = 0; i < len; i++) bq.push_back(DW'($urandom));
            send_burst();
            drain($urandom_range(100, 20), n[0]);
            repeat ($urandom_range(2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_stall();
        test_drain_inject();
        test_reset_mid_drain();
        test_sum();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
